// File: rtl/fpro_bus_pkg.sv
// Shared types and defaults for the MCS-to-FPro bridge family.
package fpro_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } brg_state_t;

    localparam logic [31:0] BRG_BASE_DEF = 32'hc000_0000;
    localparam logic [31:0] ERR_DATA_DEF = 32'hdead_beef;

endpackage

// File: rtl/fpro_addr_decode.sv
// Combinational bridge-window decoder: window hit, slot index and FPro word address.
module fpro_addr_decode
    import fpro_bus_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = BRG_BASE_DEF,
    parameter int          ADDR_W   = 21,
    parameter int          CS_BITS  = 1
) (
    input  logic [31:2]        address,
    output logic               hit,
    output logic [CS_BITS-1:0] idx,
    output logic [ADDR_W-1:0]  word_addr
);

    // Everything above the slot field is the window tag.
    localparam int TAG_LO = ADDR_W + CS_BITS + 2;

    assign hit       = (address[31:TAG_LO] == BRG_BASE[31:TAG_LO]);
    assign idx       = address[ADDR_W+2 +: CS_BITS];
    assign word_addr = address[ADDR_W+1:2];

endmodule

// File: rtl/mcs_fpro_bridge_ws.sv
// MCS IO-bus to FPro bridge with acknowledge-based wait states, bus timeout
// and a sticky error flag.
module mcs_fpro_bridge_ws
    import fpro_bus_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = BRG_BASE_DEF,
    parameter int          ADDR_W   = 21,
    parameter int          CS_BITS  = 1,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_addr_strobe,
    input  logic                    io_read_strobe,
    input  logic                    io_write_strobe,
    input  logic [3:0]              io_byte_enable,
    input  logic [31:0]             io_address,
    input  logic [31:0]             io_write_data,
    output logic [31:0]             io_read_data,
    output logic                    io_ready,
    output logic [(2**CS_BITS)-1:0] fp_cs,
    output logic                    fp_wr,
    output logic                    fp_rd,
    output logic [ADDR_W-1:0]       fp_addr,
    output logic [3:0]              fp_be,
    output logic [31:0]             fp_wr_data,
    input  logic [31:0]             fp_rd_data,
    input  logic                    fp_ack,
    output logic                    err_flag,
    input  logic                    err_clr
);

    localparam int          N_CS     = 2**CS_BITS;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    brg_state_t         state, state_next;
    logic [15:0]        cnt;
    logic               is_wr;
    logic               hit;
    logic [CS_BITS-1:0] idx;
    logic [ADDR_W-1:0]  word_addr;
    logic               req, cmd, miss, ack_take, timed_out;
    logic               io_ready_next, fp_wr_next, fp_rd_next, err_next;
    logic [N_CS-1:0]    fp_cs_next;
    logic [31:0]        rd_data_next;
    logic               unused_bits;

    // The address strobe always accompanies a read/write strobe on this bus.
    assign unused_bits = ^{io_addr_strobe, io_address[1:0]};

    fpro_addr_decode #(
        .BRG_BASE (BRG_BASE),
        .ADDR_W   (ADDR_W),
        .CS_BITS  (CS_BITS)
    ) u_decode (
        .address   (io_address[31:2]),
        .hit       (hit),
        .idx       (idx),
        .word_addr (word_addr)
    );

    assign req       = io_read_strobe | io_write_strobe;
    assign cmd       = (state == ST_IDLE) && req && hit;
    assign miss      = (state == ST_IDLE) && req && !hit;
    assign ack_take  = (state == ST_WAIT) && fp_ack;
    assign timed_out = (state == ST_WAIT) && !fp_ack && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cmd) state_next = ST_WAIT; else state_next = ST_IDLE;
            ST_WAIT: if (ack_take || timed_out) state_next = ST_RESP; else state_next = ST_WAIT;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // An acknowledge in the same cycle as the last count still wins over the timeout.
    always_comb begin
        io_ready_next = miss || ack_take || timed_out;
        fp_cs_next    = cmd ? (N_CS'(1'b1) << idx) : '0;
        fp_wr_next    = cmd && io_write_strobe;
        fp_rd_next    = cmd && !io_write_strobe;
        if (miss)           rd_data_next = 32'h0000_0000;
        else if (ack_take)  rd_data_next = is_wr ? 32'h0000_0000 : fp_rd_data;
        else if (timed_out) rd_data_next = ERR_DATA;
        else                rd_data_next = io_read_data;
        if (miss || timed_out) err_next = 1'b1;
        else if (err_clr)      err_next = 1'b0;
        else                   err_next = err_flag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 16'd0;
        end else if (cmd) begin
            cnt <= 16'd0;
        end else if ((state == ST_WAIT) && !fp_ack && (cnt != CNT_LAST)) begin
            cnt <= cnt + 16'd1;
        end else begin
            cnt <= cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_ready     <= 1'b0;
            io_read_data <= 32'h0000_0000;
            fp_cs        <= '0;
            fp_wr        <= 1'b0;
            fp_rd        <= 1'b0;
            fp_addr      <= '0;
            fp_be        <= 4'h0;
            fp_wr_data   <= 32'h0000_0000;
            err_flag     <= 1'b0;
            is_wr        <= 1'b0;
        end else begin
            io_ready     <= io_ready_next;
            io_read_data <= rd_data_next;
            fp_cs        <= fp_cs_next;
            fp_wr        <= fp_wr_next;
            fp_rd        <= fp_rd_next;
            err_flag     <= err_next;
            if (cmd) begin
                fp_addr    <= word_addr;
                fp_be      <= io_byte_enable;
                fp_wr_data <= io_write_data;
                is_wr      <= io_write_strobe;
            end
        end
    end

endmodule

// File: tb/tb_mcs_fpro_bridge_ws.sv
// Self-checking bench for mcs_fpro_bridge_ws: directed vector table, hand-written
// reset/error sequences, and randomized transactions against a reference model.
module tb_mcs_fpro_bridge_ws;

    localparam int          B_ADDR_W = 21;
    localparam int          B_CS     = 1;
    localparam int          B_TO     = 8;
    localparam logic [31:0] B_BASE   = 32'hc000_0000;
    localparam logic [31:0] B_ERR    = 32'hdead_beef;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address, io_write_data;
    logic [31:0] fp_rd_data;
    logic        fp_ack, err_clr, use4;

    logic [31:0] io_read_data, io_read_data4;
    logic        io_ready, io_ready4;
    logic [1:0]  fp_cs;
    logic [3:0]  fp_cs4;
    logic        fp_wr, fp_rd, fp_wr4, fp_rd4;
    logic [20:0] fp_addr;
    logic [19:0] fp_addr4;
    logic [3:0]  fp_be, fp_be4;
    logic [31:0] fp_wr_data, fp_wr_data4;
    logic        err_flag, err_flag4;

    int n_checks = 0;
    int n_err    = 0;

    int          obs_lat, cs_cycles;
    logic [3:0]  obs_cs, obs_be;
    logic        obs_wr, obs_rd, obs_err;
    logic [31:0] obs_addr, obs_wd, obs_data;

    always #5 clk = ~clk;

    mcs_fpro_bridge_ws #(.TIMEOUT(B_TO)) dut (
        .clk(clk), .reset(reset),
        .io_addr_strobe(io_addr_strobe & ~use4),
        .io_read_strobe(io_read_strobe & ~use4),
        .io_write_strobe(io_write_strobe & ~use4),
        .io_byte_enable(io_byte_enable), .io_address(io_address),
        .io_write_data(io_write_data), .io_read_data(io_read_data),
        .io_ready(io_ready), .fp_cs(fp_cs), .fp_wr(fp_wr), .fp_rd(fp_rd),
        .fp_addr(fp_addr), .fp_be(fp_be), .fp_wr_data(fp_wr_data),
        .fp_rd_data(fp_rd_data), .fp_ack(fp_ack),
        .err_flag(err_flag), .err_clr(err_clr)
    );

    mcs_fpro_bridge_ws #(.TIMEOUT(B_TO), .ADDR_W(20), .CS_BITS(2)) dut4 (
        .clk(clk), .reset(reset),
        .io_addr_strobe(io_addr_strobe & use4),
        .io_read_strobe(io_read_strobe & use4),
        .io_write_strobe(io_write_strobe & use4),
        .io_byte_enable(io_byte_enable), .io_address(io_address),
        .io_write_data(io_write_data), .io_read_data(io_read_data4),
        .io_ready(io_ready4), .fp_cs(fp_cs4), .fp_wr(fp_wr4), .fp_rd(fp_rd4),
        .fp_addr(fp_addr4), .fp_be(fp_be4), .fp_wr_data(fp_wr_data4),
        .fp_rd_data(fp_rd_data), .fp_ack(fp_ack),
        .err_flag(err_flag4), .err_clr(err_clr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
        logic        rd;
        int          dly;
        logic [31:0] sdata;
        logic        u4;
        int          exp_lat;
        logic [3:0]  exp_cs;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " io_ready"},     32'(io_ready),     32'd0);
        chk({tag, " io_read_data"}, io_read_data,      32'd0);
        chk({tag, " fp_cs"},        32'(fp_cs),        32'd0);
        chk({tag, " fp_wr"},        32'(fp_wr),        32'd0);
        chk({tag, " fp_rd"},        32'(fp_rd),        32'd0);
        chk({tag, " fp_addr"},      32'(fp_addr),      32'd0);
        chk({tag, " fp_be"},        32'(fp_be),        32'd0);
        chk({tag, " fp_wr_data"},   fp_wr_data,        32'd0);
        chk({tag, " err_flag"},     32'(err_flag),     32'd0);
    endtask

    // One MCS access: clear the error flag, strobe for one cycle, emulate a slave
    // acknowledging dly cycles after the command cycle (dly < 0: never).
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input logic w, input logic r, input int dly,
                           input logic [31:0] sd, input logic u4);
        logic [3:0] cur_cs;
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        use4 = u4;
        io_address = a; io_write_data = wd; io_byte_enable = be;
        io_write_strobe = w; io_read_strobe = r; io_addr_strobe = 1'b1;
        obs_lat = -1; cs_cycles = 0; obs_cs = 4'h0; obs_wr = 1'b0; obs_rd = 1'b0;
        obs_addr = 32'h0; obs_be = 4'h0; obs_wd = 32'h0; obs_data = 32'h0; obs_err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                io_write_strobe = 1'b0; io_read_strobe = 1'b0; io_addr_strobe = 1'b0;
                io_address = $urandom; io_write_data = $urandom; io_byte_enable = 4'($urandom);
            end
            fp_ack     = (n - 1 == dly);
            fp_rd_data = (n - 1 == dly) ? sd : $urandom;
            @(negedge clk);
            cur_cs = u4 ? fp_cs4 : {2'b00, fp_cs};
            if (cur_cs != 4'h0) begin
                cs_cycles++;
                obs_cs = cur_cs;
                obs_wr = u4 ? fp_wr4 : fp_wr;
                obs_rd = u4 ? fp_rd4 : fp_rd;
            end
            if (u4 ? io_ready4 : io_ready) begin
                obs_lat  = n;
                obs_data = u4 ? io_read_data4 : io_read_data;
                obs_addr = u4 ? 32'(fp_addr4) : 32'(fp_addr);
                obs_be   = u4 ? fp_be4 : fp_be;
                obs_wd   = u4 ? fp_wr_data4 : fp_wr_data;
                obs_err  = u4 ? err_flag4 : err_flag;
                break;
            end
        end
        fp_ack = 1'b0;
        use4 = 1'b0;
    endtask

    task automatic check_txn(input string tag, input int elat, input logic [3:0] ecs,
                             input logic ew, input logic er, input logic [31:0] eaddr,
                             input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic [31:0] edata, input logic eerr);
        chk({tag, " latency"},   32'(obs_lat),   32'(elat));
        chk({tag, " fp_cs"},     32'(obs_cs),    32'(ecs));
        chk({tag, " cs_cycles"}, 32'(cs_cycles), (ecs != 4'h0) ? 32'd1 : 32'd0);
        chk({tag, " fp_wr"},     32'(obs_wr),    32'(ew));
        chk({tag, " fp_rd"},     32'(obs_rd),    32'(er));
        if (ecs != 4'h0) begin
            chk({tag, " fp_addr"},    obs_addr,     eaddr);
            chk({tag, " fp_be"},      32'(obs_be),  32'(ebe));
            chk({tag, " fp_wr_data"}, obs_wd,       ewd);
        end
        chk({tag, " rd_data"},  obs_data,      edata);
        chk({tag, " err_flag"}, 32'(obs_err),  32'(eerr));
    endtask

    // Reference behaviour for the default-parameter bridge, from the address-map
    // and handshake rules expressed as plain arithmetic.
    function automatic void model(input logic [31:0] a, input logic w, input int dly,
                                  input logic [31:0] sd, output int lat, output logic [3:0] cs,
                                  output logic [31:0] waddr, output logic [31:0] d,
                                  output logic e);
        int  tag_lo;
        bit  hit, tmo;
        tag_lo = B_ADDR_W + B_CS + 2;
        hit    = ((a >> tag_lo) == (B_BASE >> tag_lo));
        tmo    = (dly < 0) || (dly >= B_TO);
        cs     = hit ? 4'(1 << ((a >> (B_ADDR_W + 2)) % (1 << B_CS))) : 4'h0;
        waddr  = (a >> 2) % (32'd1 << B_ADDR_W);
        lat    = !hit ? 1 : (tmo ? B_TO + 1 : dly + 2);
        d      = !hit ? 32'h0 : (tmo ? B_ERR : (w ? 32'h0 : sd));
        e      = !hit || tmo;
    endfunction

    initial begin
        int          lat, dly, seen;
        logic [3:0]  cs;
        logic [31:0] wa, d, a, wd, sd;
        logic        e, w, r;
        bit          hit_v;

        vecs[0]  = '{32'hc000_0010, 32'h1234_5678, 4'hf, 1'b1, 1'b0,  0, 32'h0,         1'b0, 2, 4'b0001, 32'd4,         32'h0,         1'b0};
        vecs[1]  = '{32'hc080_0008, 32'h0,         4'hf, 1'b0, 1'b1,  3, 32'hcafe_0001, 1'b0, 5, 4'b0010, 32'd2,         32'hcafe_0001, 1'b0};
        vecs[2]  = '{32'hc000_0000, 32'h0,         4'hf, 1'b0, 1'b1, -1, 32'h0,         1'b0, 9, 4'b0001, 32'd0,         32'hdead_beef, 1'b1};
        vecs[3]  = '{32'h8000_0000, 32'h0,         4'hf, 1'b0, 1'b1,  0, 32'h7777_7777, 1'b0, 1, 4'b0000, 32'd0,         32'h0,         1'b1};
        vecs[4]  = '{32'hc000_0004, 32'h0000_00ff, 4'h1, 1'b0, 1'b1,  7, 32'h0bad_f00d, 1'b0, 9, 4'b0001, 32'd1,         32'h0bad_f00d, 1'b0};
        vecs[5]  = '{32'hc000_0008, 32'h0,         4'hf, 1'b0, 1'b1,  8, 32'h1111_2222, 1'b0, 9, 4'b0001, 32'd2,         32'hdead_beef, 1'b1};
        vecs[6]  = '{32'hc080_0010, 32'ha5a5_5a5a, 4'h3, 1'b1, 1'b1,  1, 32'hffff_ffff, 1'b0, 3, 4'b0010, 32'd4,         32'h0,         1'b0};
        vecs[7]  = '{32'hc0c0_0004, 32'h0f0f_0f0f, 4'h8, 1'b1, 1'b0,  0, 32'h0,         1'b1, 2, 4'b1000, 32'd1,         32'h0,         1'b0};
        vecs[8]  = '{32'hc0ff_fffc, 32'h0,         4'hc, 1'b0, 1'b1,  2, 32'h1357_9bdf, 1'b0, 4, 4'b0010, 32'h001f_ffff, 32'h1357_9bdf, 1'b0};
        vecs[9]  = '{32'hc100_0000, 32'h1,         4'hf, 1'b1, 1'b0,  0, 32'h0,         1'b0, 1, 4'b0000, 32'd0,         32'h0,         1'b1};
        vecs[10] = '{32'hbfff_fffc, 32'h0,         4'hf, 1'b0, 1'b1,  0, 32'h0,         1'b0, 1, 4'b0000, 32'd0,         32'h0,         1'b1};

        reset = 1'b1; use4 = 1'b0; err_clr = 1'b0; fp_ack = 1'b0; fp_rd_data = 32'h0;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
        io_byte_enable = 4'h0; io_address = 32'h0; io_write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].wr, vecs[i].rd,
                    vecs[i].dly, vecs[i].sdata, vecs[i].u4);
            check_txn($sformatf("vec%0d", i), vecs[i].exp_lat, vecs[i].exp_cs,
                      (vecs[i].exp_cs != 4'h0) && vecs[i].wr,
                      (vecs[i].exp_cs != 4'h0) && vecs[i].rd && !vecs[i].wr,
                      vecs[i].exp_addr, vecs[i].be, vecs[i].wdata,
                      vecs[i].exp_data, vecs[i].exp_err);
        end

        // err_clr drops the flag on the next cycle; a set in the same cycle as err_clr wins.
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(negedge clk);
        chk("err_clr_clears", 32'(err_flag), 32'd1);
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("err_clr_next_cycle", 32'(err_flag), 32'd0);
        io_address = 32'h8000_0000; io_read_strobe = 1'b1; io_addr_strobe = 1'b1; err_clr = 1'b1;
        @(posedge clk); #1;
        io_read_strobe = 1'b0; io_addr_strobe = 1'b0; err_clr = 1'b0;
        chk("set_beats_clr err_flag", 32'(err_flag), 32'd1);
        chk("set_beats_clr io_ready", 32'(io_ready), 32'd1);

        // Read data persists after the io_ready pulse.
        run_txn(32'hc000_0040, 32'h0, 4'hf, 1'b0, 1'b1, 1, 32'h5a5a_1234, 1'b0);
        repeat (3) @(negedge clk);
        chk("rd_data_hold", io_read_data, 32'h5a5a_1234);
        chk("io_ready_pulse", 32'(io_ready), 32'd0);

        // Reset in the middle of a waiting read drops the transaction.
        @(posedge clk); #1;
        io_address = 32'hc000_0020; io_read_strobe = 1'b1; io_addr_strobe = 1'b1;
        @(posedge clk); #1;
        io_read_strobe = 1'b0; io_addr_strobe = 1'b0;
        chk("midwait fp_rd", 32'(fp_rd), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("midwait_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (io_ready) seen++;
        end
        chk("midwait no io_ready", 32'(seen), 32'd0);
        run_txn(32'hc000_0010, 32'h1234_5678, 4'hf, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        check_txn("after_reset", 2, 4'b0001, 1'b1, 1'b0, 32'd4, 4'hf, 32'h1234_5678, 32'h0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            hit_v = ($urandom_range(0, 9) < 7);
            a   = hit_v ? ((32'($urandom) & 32'h00ff_ffff) | 32'hc000_0000) : 32'($urandom);
            wd  = $urandom;
            sd  = $urandom;
            w   = 1'($urandom);
            r   = w ? 1'($urandom) : 1'b1;
            dly = $urandom_range(0, 10) - 1;
            model(a, w, dly, sd, lat, cs, wa, d, e);
            run_txn(a, wd, 4'hf, w, r, dly, sd, 1'b0);
            check_txn($sformatf("rand%0d", k), lat, cs, (cs != 4'h0) && w,
                      (cs != 4'h0) && !w, wa, 4'hf, wd, d, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
